// File: rtl/jac1_pkg.sv
// Shared definitions for the JAC1 instruction sequencer.
// Holds FSM state codes and the default counter width / halt opcode.
package jac1_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5
    } state_t;

    localparam int         DefOpBits     = 5;
    localparam int         DefCntWidth   = 16;
    localparam logic [4:0] DefHaltOpCode = 5'h1F;

endpackage

// File: rtl/jac1_sequencer.sv
// JAC1 sequencer: walks FETCH/DECODE/EXECUTE/WRITEBACK per instruction,
// supports run/step/halt control and counts retired instructions.
// Ports:
//   clk, res_n             clock, async active-low reset
//   run, step, halt_req    control (level, pulse, level)
//   opcode, dec_wr_en,
//   dec_cnt_wr_en          decoder inputs
//   ir_load_en, rd_en,
//   reg_wr_en, pc_inc_en,
//   pc_load_en             datapath strobes
//   state, halted,
//   step_ack, instr_count  status
module jac1_sequencer
    import jac1_pkg::*;
#(
    parameter int NumOpCodeBits = DefOpBits,
    parameter int CntWidth      = DefCntWidth,
    parameter logic [NumOpCodeBits-1:0] HaltOpCode =
        NumOpCodeBits'(DefHaltOpCode)
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     run,
    input  logic                     step,
    input  logic                     halt_req,
    input  logic [NumOpCodeBits-1:0] opcode,
    input  logic                     dec_wr_en,
    input  logic                     dec_cnt_wr_en,
    output logic                     ir_load_en,
    output logic                     rd_en,
    output logic                     reg_wr_en,
    output logic                     pc_inc_en,
    output logic                     pc_load_en,
    output logic [2:0]               state,
    output logic                     halted,
    output logic                     step_ack,
    output logic [CntWidth-1:0]      instr_count
);

    state_t state_q;
    state_t state_d;
    logic   step_mode_q;
    logic   step_mode_d;
    logic   retire;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q     <= S_IDLE;
            step_mode_q <= 1'b0;
            step_ack    <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q     <= state_d;
            step_mode_q <= step_mode_d;
            // Registered: pulses in the cycle after a stepped writeback.
            step_ack    <= retire && step_mode_q;
            if (retire && (instr_count != '1)) begin
                instr_count <= instr_count + CntWidth'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        step_mode_d = step_mode_q;
        ir_load_en  = 1'b0;
        rd_en       = 1'b0;
        reg_wr_en   = 1'b0;
        pc_inc_en   = 1'b0;
        pc_load_en  = 1'b0;
        retire      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!halt_req && (run || step)) begin
                    state_d = S_FETCH;
                    // run wins over step: continuous mode, no ack.
                    step_mode_d = step && !run;
                end
            end
            S_FETCH: begin
                ir_load_en = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == HaltOpCode) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                rd_en   = 1'b1;
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                reg_wr_en  = dec_wr_en;
                pc_load_en = dec_cnt_wr_en;
                pc_inc_en  = !dec_cnt_wr_en;
                retire     = 1'b1;
                if (halt_req || step_mode_q || !run) begin
                    state_d     = S_IDLE;
                    step_mode_d = 1'b0;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d     = S_IDLE;
                step_mode_d = 1'b0;
            end
        endcase
    end

    assign state  = state_q;
    assign halted = (state_q == S_HALTED);

endmodule
